// File: rtl/fnd_pkg.sv
// fnd_pkg: shared types and constants for the seven-segment scan decoder.
package fnd_pkg;

   // Classification of one sampled digit pattern
   typedef enum logic [1:0] {
      CLS_HEX  = 2'd0,
      CLS_SPIN = 2'd1,
      CLS_BAD  = 2'd2
   } seg_class_t;

   // Frame FSM: ST_Dn means "the next accepted sample must be digit n"
   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_D2   = 2'd1,
      ST_D1   = 2'd2,
      ST_D0   = 2'd3
   } frame_state_t;

   // Which digit an anode value selects
   typedef enum logic [1:0] {
      DIG_2    = 2'd0,
      DIG_1    = 2'd1,
      DIG_0    = 2'd2,
      DIG_NONE = 2'd3
   } digit_sel_t;

   // Active-low anode codes
   localparam logic [2:0] AN_DIG2 = 3'b011;
   localparam logic [2:0] AN_DIG1 = 3'b101;
   localparam logic [2:0] AN_DIG0 = 3'b110;
   localparam logic [2:0] AN_NONE = 3'b111;

   // Lit-high segment codes {a,b,c,d,e,f,g}, indexed by hex value
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic digit_sel_t anode_to_digit(input logic [2:0] anode);
      digit_sel_t sel;
      case (anode)
         AN_DIG2: sel = DIG_2;
         AN_DIG1: sel = DIG_1;
         AN_DIG0: sel = DIG_0;
         default: sel = DIG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// fnd_scan_decoder_if: display lines in, decoded page and status out.
interface fnd_scan_decoder_if;
   logic [7:0]  nFND;
   logic [2:0]  nANODE;
   logic [11:0] PAGE;
   logic        PAGE_VALID;
   logic        SPIN_ACTIVE;
   logic        FRAME_ERR;
   logic        STALE;

   // The display side drives segments and anodes
   modport master (
      output nFND, nANODE,
      input  PAGE, PAGE_VALID, SPIN_ACTIVE, FRAME_ERR, STALE
   );

   // The decoder watches the display and reports what it shows
   modport slave (
      input  nFND, nANODE,
      output PAGE, PAGE_VALID, SPIN_ACTIVE, FRAME_ERR, STALE
   );
endinterface

// File: rtl/fnd_seg_classify.sv
// fnd_seg_classify: maps a 7-bit segment pattern to a hex nibble and a class.
module fnd_seg_classify
   import fnd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output seg_class_t seg_class
);

   // Table match wins; unmatched patterns with at most one lit segment are spinner frames
   always_comb begin
      nibble    = 4'h0;
      seg_class = CLS_BAD;
      if ($countones(seg) <= 1) begin
         seg_class = CLS_SPIN;
      end
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            nibble    = 4'(i);
            seg_class = CLS_HEX;
         end
      end
   end

endmodule

// File: rtl/fnd_scan_decoder.sv
// fnd_scan_decoder: recovers the hex value shown on a multiplexed 3-digit
// seven-segment display by watching its anode and segment lines.
module fnd_scan_decoder
   import fnd_pkg::*;
#(
   parameter int SETTLE_CYC    = 16,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT_CYC   = 8192
) (
   input  logic              MCLK,
   input  logic              RST,
   fnd_scan_decoder_if.slave bus
);

   localparam int SETTLE_W  = $clog2(SETTLE_CYC + 1);
   localparam int STABLE_W  = $clog2(STABLE_FRAMES + 1);
   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [SETTLE_W-1:0]  SETTLE_MAX   = SETTLE_W'(SETTLE_CYC);
   localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYC - 1);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX  = TIMEOUT_W'(TIMEOUT_CYC);
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
   localparam logic [STABLE_W-1:0]  STABLE_MAX   = STABLE_W'(STABLE_FRAMES);
   localparam logic [STABLE_W-1:0]  STABLE_ONE   = STABLE_W'(1);

   logic [2:0]           anode_s1;
   logic [2:0]           anode_s2;
   logic [2:0]           anode_prev;
   logic [7:0]           seg_s1;
   logic [7:0]           seg_s2;
   logic                 dp_unused;

   logic                 anode_change;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic                 sample_fire;
   logic [TIMEOUT_W-1:0] timeout_cnt;
   logic                 timeout_hit;

   digit_sel_t           sample_digit;
   logic [3:0]           cls_nibble;
   seg_class_t           cls_class;

   frame_state_t         state_q;
   frame_state_t         state_d;
   logic                 frame_err_d;
   logic                 take_d2;
   logic                 take_d1;
   logic                 frame_done;

   logic [3:0]           d2_nib;
   logic [3:0]           d1_nib;
   logic                 spin_seen;
   logic [11:0]          frame_value;
   logic                 frame_spin;
   logic [11:0]          last_frame;
   logic [STABLE_W-1:0]  stable_cnt;
   logic [STABLE_W-1:0]  stable_next;

   logic [11:0]          page_q;
   logic                 page_valid_q;
   logic                 spin_active_q;
   logic                 frame_err_q;
   logic                 stale_q;

   // Two-flop synchronizers on the display lines, plus last cycle's anode for change detection
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         anode_s1   <= AN_NONE;
         anode_s2   <= AN_NONE;
         anode_prev <= AN_NONE;
         seg_s1     <= 8'h00;
         seg_s2     <= 8'h00;
      end else begin
         anode_s1   <= bus.nANODE;
         anode_s2   <= anode_s1;
         anode_prev <= anode_s2;
         seg_s1     <= bus.nFND;
         seg_s2     <= seg_s1;
      end
   end

   assign dp_unused    = seg_s2[0];
   assign anode_change = (anode_s2 != anode_prev);

   // Settle counter restarts on every anode change and parks at its limit so each period samples once
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         settle_cnt <= '0;
      end else if (anode_change) begin
         settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   assign sample_fire = !anode_change && (settle_cnt == SETTLE_LAST);

   // Timeout counter measures time since the last anode change and saturates instead of wrapping
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         timeout_cnt <= '0;
      end else if (anode_change) begin
         timeout_cnt <= '0;
      end else if (timeout_cnt != TIMEOUT_MAX) begin
         timeout_cnt <= timeout_cnt + 1'b1;
      end
   end

   assign timeout_hit  = !anode_change && (timeout_cnt == TIMEOUT_LAST);
   assign sample_digit = anode_to_digit(anode_s2);

   fnd_seg_classify u_classify (
      .seg       (seg_s2[7:1]),
      .nibble    (cls_nibble),
      .seg_class (cls_class)
   );

   // Frame FSM state register
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame FSM: accept samples in digit2/digit1/digit0 order, flag anything else as an aborted frame
   always_comb begin
      state_d     = state_q;
      frame_err_d = 1'b0;
      take_d2     = 1'b0;
      take_d1     = 1'b0;
      frame_done  = 1'b0;
      if (timeout_hit) begin
         state_d = ST_SYNC;
      end else if (sample_fire) begin
         if ((sample_digit == DIG_NONE) || (cls_class == CLS_BAD)) begin
            frame_err_d = 1'b1;
            state_d     = ST_SYNC;
         end else begin
            case (state_q)
               ST_SYNC: begin
                  if (sample_digit == DIG_2) begin
                     take_d2 = 1'b1;
                     state_d = ST_D1;
                  end
               end
               ST_D2: begin
                  if (sample_digit == DIG_2) begin
                     take_d2 = 1'b1;
                     state_d = ST_D1;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_SYNC;
                  end
               end
               ST_D1: begin
                  if (sample_digit == DIG_1) begin
                     take_d1 = 1'b1;
                     state_d = ST_D0;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_SYNC;
                  end
               end
               ST_D0: begin
                  if (sample_digit == DIG_0) begin
                     frame_done = 1'b1;
                     state_d    = ST_D2;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_SYNC;
                  end
               end
               default: state_d = ST_SYNC;
            endcase
         end
      end
   end

   // Hold the first two digits of the frame in progress and whether any of them was a spinner
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         d2_nib    <= 4'h0;
         d1_nib    <= 4'h0;
         spin_seen <= 1'b0;
      end else if (take_d2) begin
         d2_nib    <= cls_nibble;
         spin_seen <= (cls_class == CLS_SPIN);
      end else if (take_d1) begin
         d1_nib    <= cls_nibble;
         spin_seen <= spin_seen | (cls_class == CLS_SPIN);
      end
   end

   assign frame_value = {d2_nib, d1_nib, cls_nibble};
   assign frame_spin  = spin_seen | (cls_class == CLS_SPIN);

   // Stable-frame count a completing hex frame would produce
   always_comb begin
      stable_next = STABLE_ONE;
      if (frame_value == last_frame) begin
         stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : (stable_cnt + STABLE_ONE);
      end
   end

   // Frame results: stability tracking, page load, spinner flag, and clean-up on errors and timeout
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         last_frame    <= 12'h000;
         stable_cnt    <= '0;
         page_q        <= 12'h000;
         page_valid_q  <= 1'b0;
         spin_active_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         if (timeout_hit) begin
            stable_cnt    <= '0;
            page_valid_q  <= 1'b0;
            spin_active_q <= 1'b0;
         end else if (frame_err_d) begin
            stable_cnt <= '0;
         end else if (frame_done) begin
            if (frame_spin) begin
               stable_cnt    <= '0;
               page_valid_q  <= 1'b0;
               spin_active_q <= 1'b1;
            end else begin
               last_frame    <= frame_value;
               stable_cnt    <= stable_next;
               spin_active_q <= 1'b0;
               if (stable_next == STABLE_MAX) begin
                  page_q       <= frame_value;
                  page_valid_q <= 1'b1;
               end
            end
         end
      end
   end

   // Stale flag sets on timeout expiry and clears on the next anode change
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         stale_q <= 1'b0;
      end else if (anode_change) begin
         stale_q <= 1'b0;
      end else if (timeout_hit) begin
         stale_q <= 1'b1;
      end
   end

   assign bus.PAGE        = page_q;
   assign bus.PAGE_VALID  = page_valid_q;
   assign bus.SPIN_ACTIVE = spin_active_q;
   assign bus.FRAME_ERR   = frame_err_q;
   assign bus.STALE       = stale_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb_fnd_scan_decoder: table vectors, directed corner sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_fnd_scan_decoder;

   localparam int SETTLE_CYC    = 16;
   localparam int STABLE_FRAMES = 2;
   localparam int TIMEOUT_CYC   = 8192;
   localparam logic [2:0] A2 = 3'b011;
   localparam logic [2:0] A1 = 3'b101;
   localparam logic [2:0] A0 = 3'b110;

   typedef struct {
      logic [7:0]  fnd2;
      logic [7:0]  fnd1;
      logic [7:0]  fnd0;
      int          frames;
      int          period;
      logic [11:0] page;
      logic        valid;
      logic        spin;
   } vec_t;

   logic        MCLK;
   logic        RST;
   int          checks;
   int          errors;
   int          errHigh;
   int          errRise;
   logic        errPrev;
   int          baseHigh;
   int          baseRise;
   logic [6:0]  hexSeg [16];
   logic [6:0]  badSeg [4];
   vec_t        tbl [10];

   logic [11:0] mPage;
   logic        mValid;
   logic        mSpin;
   int          mCount;
   logic [11:0] mLast;
   int          mErrs;

   fnd_scan_decoder_if bus ();

   fnd_scan_decoder #(
      .SETTLE_CYC    (SETTLE_CYC),
      .STABLE_FRAMES (STABLE_FRAMES),
      .TIMEOUT_CYC   (TIMEOUT_CYC)
   ) dut (
      .MCLK (MCLK),
      .RST  (RST),
      .bus  (bus)
   );

   initial MCLK = 1'b0;
   always #10 MCLK = ~MCLK;

   // Count FRAME_ERR high cycles and rising edges, sampled away from the active edge
   initial begin
      errHigh = 0;
      errRise = 0;
      errPrev = 1'b0;
      forever begin
         @(negedge MCLK);
         if (bus.FRAME_ERR === 1'b1) errHigh++;
         if (bus.FRAME_ERR === 1'b1 && errPrev !== 1'b1) errRise++;
         errPrev = bus.FRAME_ERR;
      end
   end

   // Hard stop in case the run ever wedges
   initial begin
      #4000000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] anode, input logic [7:0] fnd, input int cycles);
      bus.nANODE = anode;
      bus.nFND   = fnd;
      repeat (cycles) @(negedge MCLK);
   endtask

   task automatic scanFrame(input logic [7:0] f2, input logic [7:0] f1, input logic [7:0] f0, input int period);
      applyStimulus(A2, f2, period);
      applyStimulus(A1, f1, period);
      applyStimulus(A0, f0, period);
   endtask

   function automatic logic [7:0] hx(input int n, input logic dp);
      return {hexSeg[n], dp};
   endfunction

   task automatic checkReset(input string tag);
      checkOutput({tag, " PAGE"}, 32'(bus.PAGE), 32'h000);
      checkOutput({tag, " PAGE_VALID"}, 32'(bus.PAGE_VALID), 32'd0);
      checkOutput({tag, " SPIN_ACTIVE"}, 32'(bus.SPIN_ACTIVE), 32'd0);
      checkOutput({tag, " FRAME_ERR"}, 32'(bus.FRAME_ERR), 32'd0);
      checkOutput({tag, " STALE"}, 32'(bus.STALE), 32'd0);
   endtask

   // Frame-level reference: what the display showed decides the outputs
   task automatic modelFrame(input int kind, input logic [11:0] val);
      if (kind == 0) begin
         if (val == mLast) mCount = (mCount >= STABLE_FRAMES) ? STABLE_FRAMES : mCount + 1;
         else mCount = 1;
         mLast = val;
         mSpin = 1'b0;
         if (mCount == STABLE_FRAMES) begin
            mPage  = val;
            mValid = 1'b1;
         end
      end else if (kind == 1) begin
         mSpin  = 1'b1;
         mValid = 1'b0;
         mCount = 0;
      end else begin
         mCount = 0;
         mErrs++;
      end
   endtask

   initial begin
      int          kind;
      int          which;
      int          k;
      logic [11:0] val;
      logic [11:0] prevHex;
      logic        haveHex;
      logic [7:0]  fnd [3];
      logic [11:0] pool [4];

      checks = 0;
      errors = 0;
      hexSeg = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      badSeg = '{7'b1100000, 7'b0000011, 7'b1010101, 7'b0101010};

      tbl[0] = '{hx(1,0), hx(2,0), hx(3,0), 1, 1024, 12'h000, 1'b0, 1'b0};
      tbl[1] = '{hx(1,0), hx(2,0), hx(3,0), 1, 1024, 12'h123, 1'b1, 1'b0};
      tbl[2] = '{hx(1,0), hx(2,0), hx(3,0), 1, 1024, 12'h123, 1'b1, 1'b0};
      tbl[3] = '{hx(1,0), hx(2,0), hx(4,0), 1, 64,   12'h123, 1'b1, 1'b0};
      tbl[4] = '{hx(1,0), hx(2,0), hx(4,0), 1, 64,   12'h124, 1'b1, 1'b0};
      tbl[5] = '{8'b1000000_0, 8'h00, 8'b0000001_0, 1, 64, 12'h124, 1'b0, 1'b1};
      tbl[6] = '{8'h01, hx(5,0), hx(5,1), 1, 64, 12'h124, 1'b0, 1'b1};
      tbl[7] = '{hx(10,0), hx(11,0), hx(12,0), 1, 64, 12'h124, 1'b0, 1'b0};
      tbl[8] = '{hx(10,0), hx(11,0), hx(12,0), 1, 64, 12'hABC, 1'b1, 1'b0};
      tbl[9] = '{hx(15,1), hx(0,1), hx(14,1), 2, 64, 12'hF0E, 1'b1, 1'b0};

      // Reset state
      RST        = 1'b1;
      bus.nANODE = A0;
      bus.nFND   = 8'h00;
      repeat (5) @(negedge MCLK);
      checkReset("reset");
      RST = 1'b0;

      // Table-driven frame vectors; state carries from one entry to the next
      baseRise = errRise;
      for (int i = 0; i < 10; i++) begin
         for (int f = 0; f < tbl[i].frames; f++) begin
            scanFrame(tbl[i].fnd2, tbl[i].fnd1, tbl[i].fnd0, tbl[i].period);
         end
         checkOutput($sformatf("vec%0d PAGE", i), 32'(bus.PAGE), 32'(tbl[i].page));
         checkOutput($sformatf("vec%0d PAGE_VALID", i), 32'(bus.PAGE_VALID), 32'(tbl[i].valid));
         checkOutput($sformatf("vec%0d SPIN_ACTIVE", i), 32'(bus.SPIN_ACTIVE), 32'(tbl[i].spin));
      end
      checkOutput("vectors FRAME_ERR pulses", 32'(errRise - baseRise), 32'd0);

      // Out-of-order digit: one-cycle error pulse and the stable count starts over
      scanFrame(hx(5,0), hx(5,0), hx(5,0), 64);
      baseRise = errRise;
      baseHigh = errHigh;
      applyStimulus(A2, hx(5,0), 64);
      applyStimulus(A0, hx(5,0), 64);
      checkOutput("order FRAME_ERR pulses", 32'(errRise - baseRise), 32'd1);
      checkOutput("order FRAME_ERR width", 32'(errHigh - baseHigh), 32'd1);
      scanFrame(hx(5,0), hx(5,0), hx(5,0), 64);
      checkOutput("order count cleared PAGE", 32'(bus.PAGE), 32'hF0E);
      scanFrame(hx(5,0), hx(5,0), hx(5,0), 64);
      checkOutput("order recover PAGE", 32'(bus.PAGE), 32'h555);
      checkOutput("order recover PAGE_VALID", 32'(bus.PAGE_VALID), 32'd1);

      // BAD digit mid-frame and an illegal anode each abort the frame
      baseRise = errRise;
      scanFrame(hx(1,0), {badSeg[0], 1'b0}, hx(1,0), 64);
      checkOutput("bad digit FRAME_ERR", 32'(errRise - baseRise), 32'd1);
      checkOutput("bad digit PAGE held", 32'(bus.PAGE), 32'h555);
      baseRise = errRise;
      applyStimulus(3'b001, hx(1,0), 64);
      checkOutput("illegal anode FRAME_ERR", 32'(errRise - baseRise), 32'd1);

      // Anode frozen at digit1 until stale, then released
      baseRise = errRise;
      applyStimulus(A2, hx(1,0), 64);
      applyStimulus(A1, hx(2,0), TIMEOUT_CYC - 50);
      checkOutput("before timeout STALE", 32'(bus.STALE), 32'd0);
      applyStimulus(A1, hx(2,0), 100);
      checkOutput("timeout STALE", 32'(bus.STALE), 32'd1);
      checkOutput("timeout PAGE_VALID", 32'(bus.PAGE_VALID), 32'd0);
      checkOutput("timeout SPIN_ACTIVE", 32'(bus.SPIN_ACTIVE), 32'd0);
      applyStimulus(A0, hx(3,0), 8);
      checkOutput("change clears STALE", 32'(bus.STALE), 32'd0);
      applyStimulus(A0, hx(3,0), 56);
      checkOutput("stale no FRAME_ERR", 32'(errRise - baseRise), 32'd0);

      // Change arriving just before expiry keeps STALE low
      applyStimulus(A2, hx(1,0), TIMEOUT_CYC - 20);
      checkOutput("near timeout STALE", 32'(bus.STALE), 32'd0);
      applyStimulus(A1, hx(2,0), 64);
      checkOutput("change before expiry STALE", 32'(bus.STALE), 32'd0);
      applyStimulus(A0, hx(3,0), 64);
      checkOutput("after stale one frame PAGE_VALID", 32'(bus.PAGE_VALID), 32'd0);
      scanFrame(hx(1,0), hx(2,0), hx(3,0), 64);
      checkOutput("after stale PAGE", 32'(bus.PAGE), 32'h123);
      checkOutput("after stale PAGE_VALID", 32'(bus.PAGE_VALID), 32'd1);

      // Reset in the middle of a frame after ABC was shown
      scanFrame(hx(10,0), hx(11,0), hx(12,0), 64);
      scanFrame(hx(10,0), hx(11,0), hx(12,0), 64);
      checkOutput("pre-reset PAGE", 32'(bus.PAGE), 32'hABC);
      applyStimulus(A2, hx(10,0), 10);
      #3 RST = 1'b1;
      #1 checkReset("async reset");
      repeat (3) @(negedge MCLK);
      RST = 1'b0;
      scanFrame(hx(10,0), hx(11,0), hx(12,0), 64);
      checkOutput("reset recover 1 PAGE", 32'(bus.PAGE), 32'h000);
      checkOutput("reset recover 1 PAGE_VALID", 32'(bus.PAGE_VALID), 32'd0);
      scanFrame(hx(10,0), hx(11,0), hx(12,0), 64);
      checkOutput("reset recover 2 PAGE", 32'(bus.PAGE), 32'hABC);
      checkOutput("reset recover 2 PAGE_VALID", 32'(bus.PAGE_VALID), 32'd1);

      // Randomized frame stream against the reference model
      RST = 1'b1;
      repeat (3) @(negedge MCLK);
      RST      = 1'b0;
      mPage    = 12'h000;
      mValid   = 1'b0;
      mSpin    = 1'b0;
      mCount   = 0;
      mLast    = 12'h000;
      mErrs    = 0;
      haveHex  = 1'b0;
      prevHex  = 12'h000;
      baseRise = errRise;
      pool[0]  = 12'h123;
      pool[1]  = 12'h124;
      pool[2]  = 12'hABC;
      for (int f = 0; f < 24; f++) begin
         pool[3] = 12'($urandom);
         k = $urandom_range(0, 99);
         kind = (k < 60) ? 0 : ((k < 85) ? 1 : 2);
         if (haveHex && $urandom_range(0, 1) == 1) val = prevHex;
         else val = pool[$urandom_range(0, 3)];
         for (int d = 0; d < 3; d++) begin
            fnd[d] = hx(int'(4'(val >> (4 * (2 - d)))), 1'($urandom));
         end
         which = $urandom_range(0, 2);
         if (kind == 1) begin
            k = $urandom_range(0, 7);
            fnd[which] = {((k == 7) ? 7'd0 : 7'(1 << k)), 1'($urandom)};
         end else if (kind == 2) begin
            fnd[which] = {badSeg[$urandom_range(0, 3)], 1'($urandom)};
         end
         scanFrame(fnd[0], fnd[1], fnd[2], 48);
         modelFrame(kind, val);
         if (kind == 0) begin
            prevHex = val;
            haveHex = 1'b1;
         end
         checkOutput($sformatf("rand%0d PAGE", f), 32'(bus.PAGE), 32'(mPage));
         checkOutput($sformatf("rand%0d PAGE_VALID", f), 32'(bus.PAGE_VALID), 32'(mValid));
         checkOutput($sformatf("rand%0d SPIN_ACTIVE", f), 32'(bus.SPIN_ACTIVE), 32'(mSpin));
      end
      checkOutput("rand FRAME_ERR pulses", 32'(errRise - baseRise), 32'(mErrs));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
